keccak_padder: RTL and testbench
================================

Name: keccak_padder

Overview:
- Upstream feeder for the Keccak f-permutation stage. Collects 32-bit message words into a 576-bit rate block and applies multi-rate padding (pad start byte, zero fill, final 0x80).
- Presents each full block with a ready flag and holds it until the permutation acknowledges it.
- One message per reset. After the final padded block is consumed, the block stays idle until reset.

Parameters:
- RATE_WORDS, 18, 32-bit words per block (576 bits).
- PAD_START, 8'h01, first padding byte (domain/pad start byte).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = asserted).
- in  input  32  message word; in[31:24] is the earliest byte.
- in_ready  input  1  upstream has a valid word on in.
- is_last  input  1  current word is the final (possibly partial) word.
- byte_num  input  2  valid bytes in the last word (0..3), MSB-first; ignored when is_last=0.
- ack  output  1  word accepted this cycle (combinational).
- out  output  576  block; word 0 in out[575:544].
- out_ready  output  1  out holds a complete block.
- f_ack  input  1  permutation consumed out.

Behaviour:
- Reset values: out=0, out_ready=0, word count=0, state=FILL, done=0.
- Accept condition: ack = in_ready & (state==FILL) & ~out_ready & ~done.
- Accepted words shift into out from the LSB side (out <= {out[543:0], word}). The word count increments on each accept.
- Word when is_last=0: the word is in unchanged.
- Word when is_last=1: the valid bytes are kept, the byte at position byte_num is PAD_START, and lower bytes are 0. Examples: byte_num=0 gives {PAD_START,24'h0}; byte_num=3 gives {in[31:8],PAD_START}. Then state goes to PAD.
- PAD state: one zero word is shifted per cycle, with no upstream handshake and ack=0. This continues until the block holds RATE_WORDS words.
- Final 0x80: the last word of the padded block has its low byte ORed with 8'h80. If the pad-start byte lands in byte 71, that byte becomes PAD_START|0x80 (0x81).
  - Because byte_num<=3, padding always fits in the current block. No extra block is ever generated.
- Block completion: the cycle the RATE_WORDS-th word is shifted in, out_ready goes to 1 on the next edge and the count resets to 0.
  - If the block was padded, done is set together with out_ready.
- Hold: while out_ready=1, out is held stable and ack=0.
- Consumption: f_ack=1 while out_ready=1 clears out_ready on the next edge. out contents persist but will be overwritten.
  - f_ack while out_ready=0 is ignored.
- After f_ack on a non-final block: state=FILL and acceptance resumes the following cycle. No same-cycle accept with f_ack.
- After f_ack on the final block: done stays 1, ack stays 0 and out_ready stays 0 until reset.
- Latency: word N accepted in cycle t. If it is the 18th word, out_ready=1 at t+1. A last word at position k gives out_ready at t+(18-k)+1.
- Reset asserted mid-block or mid-pad: all state clears asynchronously, the partial block is discarded, and out_ready drops immediately.
- States: FILL, PAD, FULL (out_ready=1), DONE.
  - FILL -> PAD on an accepted last word with count<17.
  - FILL/PAD -> FULL on the 18th word.
  - FULL -> FILL on f_ack with done=0.
  - FULL -> DONE on f_ack with done=1.

Decomposition:
- Shared package: RATE_WORDS, RATE_BITS=576, the PAD_START default, the 8'h80 final-pad constant, and the state enum.
- One natural sub-module, keccak_pad_word: combinational (in, byte_num, is_last) -> padded 32-bit word.
- Counter, FSM and shift register stay in the top.

Test Plan:
- Empty message: is_last=1, byte_num=0 on the first word. Expect out = 32'h01000000 followed by zeros with out[7:0]=8'h80. out_ready rises 18 cycles after accept.
- 3-byte message "abc": in=32'h61626300, byte_num=3, is_last=1. Expect word0=32'h61626301, last byte 0x80, done=1 after f_ack, and ack stays 0 afterwards.
- 18 full words then last word with byte_num=0, with f_ack held low 5 cycles after the first out_ready. Expect ack=0 and out stable during the hold. The second block is {32'h01000000, 16 zero words, 32'h00000080}.
- Pad-start in byte 71: 17 full words plus last word 32'hAABBCC00, byte_num=3. Expect out[31:0]=32'hAABBCC81 and no second block.
- Async reset asserted mid-PAD (count=9). Expect out_ready=0 and out=0 before the next clock edge. A fresh "abc" afterwards yields the same block as the second scenario.
- in_ready held high with out_ready=1 and f_ack pulsed. Expect no accept in the f_ack cycle and the first accept exactly one cycle later.

Source files
------------

// File: rtl/keccak_padder_pkg.sv
// Shared constants and state encoding for the Keccak rate-block padder.
package keccak_padder_pkg;

  localparam int RATE_WORDS = 18;
  localparam int RATE_BITS  = 32 * RATE_WORDS;

  localparam logic [7:0] PAD_START_DEFAULT = 8'h01;
  localparam logic [7:0] FINAL_PAD         = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FULL,
    DONE
  } pad_state_t;

endpackage

// File: rtl/keccak_padder_if.sv
// Message-word input, block output and permutation handshake of the padder.
interface keccak_padder_if #(
  parameter int RATE_BITS = keccak_padder_pkg::RATE_BITS
);

  logic [31:0]          in;
  logic                 in_ready;
  logic                 is_last;
  logic [1:0]           byte_num;
  logic                 ack;
  logic [RATE_BITS-1:0] out;
  logic                 out_ready;
  logic                 f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  ack, out, out_ready
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output ack, out, out_ready
  );

endinterface

// File: rtl/keccak_pad_word.sv
// Builds the padded final word: valid bytes kept MSB-first, pad-start byte, zeros below.
module keccak_pad_word
  import keccak_padder_pkg::*;
#(
  parameter logic [7:0] PAD_START = PAD_START_DEFAULT
) (
  input  logic [31:0] word,
  input  logic [1:0]  byte_num,
  input  logic        is_last,
  output logic [31:0] padded
);

  always_comb begin
    padded = word;
    if (is_last) begin
      case (byte_num)
        2'd0:    padded = {PAD_START, 24'h0};
        2'd1:    padded = {word[31:24], PAD_START, 16'h0};
        2'd2:    padded = {word[31:16], PAD_START, 8'h0};
        default: padded = {word[31:8], PAD_START};
      endcase
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Collects 32-bit message words into a rate block, pads the final block and
// holds each block until the permutation acknowledges it.
module keccak_padder
  import keccak_padder_pkg::*;
#(
  parameter int         RATE_WORDS = keccak_padder_pkg::RATE_WORDS,
  parameter logic [7:0] PAD_START  = PAD_START_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  keccak_padder_if.slave io
);

  localparam int BLOCK_BITS = 32 * RATE_WORDS;
  localparam int CW         = $clog2(RATE_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);

  pad_state_t state, state_next;

  logic [CW-1:0]         count;
  logic                  done;
  logic                  out_ready_q;
  logic [BLOCK_BITS-1:0] block_q;

  logic        accept;
  logic        shift_en;
  logic        last_slot;
  logic        padded_block;
  logic [31:0] padded_word;
  logic [31:0] shift_word;

  keccak_pad_word #(
    .PAD_START(PAD_START)
  ) u_pad_word (
    .word    (io.in),
    .byte_num(io.byte_num),
    .is_last (io.is_last),
    .padded  (padded_word)
  );

  // The 0x80 terminator only belongs to the block that carries the padding.
  always_comb begin
    accept       = io.in_ready && (state == FILL) && !out_ready_q && !done;
    shift_en     = accept || (state == PAD);
    last_slot    = (count == LAST_IDX);
    padded_block = (state == PAD) || (accept && io.is_last);
    shift_word   = (state == PAD) ? 32'h0 : padded_word;
    if (last_slot && padded_block) begin
      shift_word[7:0] = shift_word[7:0] | FINAL_PAD;
    end

    state_next = state;
    case (state)
      FILL: begin
        if (accept) begin
          if (last_slot)       state_next = FULL;
          else if (io.is_last) state_next = PAD;
        end
      end
      PAD:     if (last_slot) state_next = FULL;
      FULL:    if (io.f_ack)  state_next = done ? DONE : FILL;
      DONE:    state_next = DONE;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_q     <= '0;
      count       <= '0;
      out_ready_q <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (shift_en) begin
        block_q <= {block_q[BLOCK_BITS-33:0], shift_word};
        count   <= last_slot ? '0 : count + 1'b1;
      end
      if (shift_en && last_slot) begin
        out_ready_q <= 1'b1;
        if (padded_block) done <= 1'b1;
      end else if (out_ready_q && io.f_ack) begin
        out_ready_q <= 1'b0;
      end
    end
  end

  assign io.ack       = accept;
  assign io.out       = block_q;
  assign io.out_ready = out_ready_q;

endmodule

// File: tb/tb_keccak_padder.sv
// Directed self-checking bench for keccak_padder with hand-computed blocks.
module tb_keccak_padder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  keccak_padder_if #(.RATE_BITS(576)) bus ();

  keccak_padder dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [575:0] observed,
                              input logic [575:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] w, input logic last,
                                input logic [1:0] bn);
    bus.in       = w;
    bus.in_ready = 1'b1;
    bus.is_last  = last;
    bus.byte_num = bn;
    #1;
  endtask

  task automatic send_word(input string tag, input logic [31:0] w, input logic last,
                           input logic [1:0] bn);
    apply_stimulus(w, last, bn);
    check_output(tag, 576'(bus.ack), 576'(1'b1));
    tick();
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_f_ack();
    bus.f_ack = 1'b1;
    tick();
    bus.f_ack = 1'b0;
    #1;
  endtask

  function automatic logic [575:0] two_word_block(input logic [31:0] first,
                                                  input logic [31:0] last_w);
    logic [575:0] b;
    b          = '0;
    b[575:544] = first;
    b[31:0]    = last_w;
    return b;
  endfunction

  logic [575:0] full_block;
  logic [575:0] abc_block;

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.in       = 32'h0;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.byte_num = 2'd0;
    bus.f_ack    = 1'b0;
    abc_block    = two_word_block(32'h61626301, 32'h00000080);

    #12;
    check_output("reset_out", bus.out, 576'h0);
    check_output("reset_out_ready", 576'(bus.out_ready), 576'(1'b0));
    reset = 1'b1;
    tick();

    // Empty message: pad start in byte 0, terminator 17 words later.
    send_word("empty_ack", 32'hDEADBEEF, 1'b1, 2'd0);
    apply_stimulus(32'h12345678, 1'b0, 2'd0);
    check_output("empty_pad_no_ack", 576'(bus.ack), 576'(1'b0));
    repeat (16) tick();
    check_output("empty_not_ready_early", 576'(bus.out_ready), 576'(1'b0));
    tick();
    check_output("empty_ready", 576'(bus.out_ready), 576'(1'b1));
    check_output("empty_block", bus.out, two_word_block(32'h01000000, 32'h00000080));
    check_output("empty_hold_no_ack", 576'(bus.ack), 576'(1'b0));
    pulse_f_ack();
    check_output("empty_consumed", 576'(bus.out_ready), 576'(1'b0));
    check_output("empty_out_persists", bus.out,
                 two_word_block(32'h01000000, 32'h00000080));
    repeat (3) begin
      tick();
      check_output("empty_done_no_ack", 576'(bus.ack), 576'(1'b0));
      check_output("empty_done_no_ready", 576'(bus.out_ready), 576'(1'b0));
    end
    bus.in_ready = 1'b0;

    // "abc" in a single last word.
    do_reset();
    send_word("abc_ack", 32'h61626300, 1'b1, 2'd3);
    repeat (17) tick();
    check_output("abc_ready", 576'(bus.out_ready), 576'(1'b1));
    check_output("abc_block", bus.out, abc_block);
    pulse_f_ack();
    apply_stimulus(32'h11223344, 1'b0, 2'd0);
    repeat (3) begin
      check_output("abc_done_no_ack", 576'(bus.ack), 576'(1'b0));
      tick();
    end
    check_output("abc_done_no_ready", 576'(bus.out_ready), 576'(1'b0));
    bus.in_ready = 1'b0;

    // Full block, held for 5 cycles, then a padding-only second block.
    do_reset();
    full_block = '0;
    for (int i = 0; i < 18; i++) begin
      full_block[575-32*i -: 32] = 32'h11110000 + 32'(i);
      send_word("full_ack", 32'h11110000 + 32'(i), 1'b0, 2'd0);
    end
    check_output("full_ready", 576'(bus.out_ready), 576'(1'b1));
    check_output("full_block", bus.out, full_block);
    apply_stimulus(32'h99999999, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      check_output("hold_no_ack", 576'(bus.ack), 576'(1'b0));
      check_output("hold_out_stable", bus.out, full_block);
      check_output("hold_ready", 576'(bus.out_ready), 576'(1'b1));
      tick();
    end
    bus.f_ack = 1'b1;
    #1;
    check_output("f_ack_cycle_no_ack", 576'(bus.ack), 576'(1'b0));
    tick();
    bus.f_ack = 1'b0;
    #1;
    check_output("after_f_ack_ready_low", 576'(bus.out_ready), 576'(1'b0));
    check_output("after_f_ack_accept", 576'(bus.ack), 576'(1'b1));
    tick();
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    repeat (16) tick();
    check_output("second_not_ready_early", 576'(bus.out_ready), 576'(1'b0));
    tick();
    check_output("second_ready", 576'(bus.out_ready), 576'(1'b1));
    check_output("second_block", bus.out, two_word_block(32'h01000000, 32'h00000080));
    pulse_f_ack();
    apply_stimulus(32'h55555555, 1'b0, 2'd0);
    check_output("second_done_no_ack", 576'(bus.ack), 576'(1'b0));
    bus.in_ready = 1'b0;

    // Pad start lands in the very last byte of the block.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_word("b71_ack", 32'h22220000 + 32'(i), 1'b0, 2'd0);
    end
    send_word("b71_last_ack", 32'hAABBCC00, 1'b1, 2'd3);
    check_output("b71_ready", 576'(bus.out_ready), 576'(1'b1));
    check_output("b71_low_word", 576'(bus.out[31:0]), 576'(32'hAABBCC81));
    check_output("b71_first_word", 576'(bus.out[575:544]), 576'(32'h22220000));
    pulse_f_ack();
    apply_stimulus(32'h66666666, 1'b0, 2'd0);
    repeat (4) begin
      check_output("b71_no_second_ack", 576'(bus.ack), 576'(1'b0));
      tick();
      check_output("b71_no_second_ready", 576'(bus.out_ready), 576'(1'b0));
    end
    bus.in_ready = 1'b0;

    // Asynchronous reset mid-PAD, then a fresh "abc".
    do_reset();
    send_word("rst_abc_ack", 32'h61626300, 1'b1, 2'd3);
    repeat (8) tick();
    reset = 1'b0;
    #1;
    check_output("rst_mid_pad_out", bus.out, 576'h0);
    check_output("rst_mid_pad_ready", 576'(bus.out_ready), 576'(1'b0));
    reset = 1'b1;
    tick();
    send_word("fresh_abc_ack", 32'h61626300, 1'b1, 2'd3);
    repeat (17) tick();
    check_output("fresh_abc_ready", 576'(bus.out_ready), 576'(1'b1));
    check_output("fresh_abc_block", bus.out, abc_block);
    reset = 1'b0;
    #1;
    check_output("rst_full_ready_drop", 576'(bus.out_ready), 576'(1'b0));
    check_output("rst_full_out", bus.out, 576'h0);
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
